uart_tx_arb: RTL



---
 rtl/uart_tx_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter sharing one UART TX serializer among NumReq byte streams.
// A grant is held until a last-flagged beat, or until MaxBeats beats force a release.
//
// state  | meaning
// IDLE   | no owner; pick the next valid requester starting at rr_ptr
// LOCKED | owner's stream passes straight through to the serializer

module uart_tx_arb #(
  parameter int NumReq   = 2,
  parameter int Width    = 8,
  parameter int MaxBeats = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*Width-1:0]   req_data_i,
  input  logic [NumReq-1:0]         req_last_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      tx_valid_o,
  output logic [Width-1:0]          tx_data_o,
  input  logic                      tx_ready_i,
  output logic [$clog2(NumReq)-1:0] grant_o,
  output logic                      busy_o,
  output logic                      overflow_o
);

  localparam int GW = $clog2(NumReq);
  localparam int CW = 8;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] grant_next;
  logic          beat;

  // rr_ptr and grant are not restricted to powers of two, so wrap explicitly
  assign grant_next = (int'(grant_q) == NumReq - 1) ? '0 : grant_q + GW'(1);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!pick_found && req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    busy_o      = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    overflow_o  = 1'b0;
    beat        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        busy_o               = 1'b1;
        tx_valid_o           = req_valid_i[grant_q];
        tx_data_o            = req_data_i[grant_q*Width +: Width];
        req_ready_o[grant_q] = tx_ready_i;
        beat                 = tx_valid_o & tx_ready_i;
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (req_last_i[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = grant_next;
          end else if (beat_cnt_q == CW'(MaxBeats - 1)) begin
            overflow_o = 1'b1;
            state_d    = IDLE;
            rr_ptr_d   = grant_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o = grant_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
